// File: rtl/controle_es.sv
// controle_es: I/O sequencer requesting a freeze for IN/OUT and completing on Enter.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   exec_in, exec_out         IN/OUT instruction decoded (levels, held while current)
//   dado_reg                  register value shown by OUT
//   chaves                    raw board switches (asynchronous)
//   congela                   freeze state from the freeze controller
//   req_congela_in/out        freeze requests (never both high)
//   dado_in, escreve_in       extended switch value and its one-cycle write pulse
//   display                   value latched by the last accepted OUT
//   concluido                 one-cycle pulse when an I/O instruction completes
//   erro                      sticky: a request timed out waiting for congela
//   ocupado                   sequencer not idle
module controle_es #(
    parameter int DATA_W    = 32,
    parameter int SW_W      = 10,
    parameter int EXT_SINAL = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exec_in,
    input  logic              exec_out,
    input  logic [DATA_W-1:0] dado_reg,
    input  logic [SW_W-1:0]   chaves,
    input  logic              congela,
    output logic              req_congela_in,
    output logic              req_congela_out,
    output logic [DATA_W-1:0] dado_in,
    output logic              escreve_in,
    output logic [DATA_W-1:0] display,
    output logic              concluido,
    output logic              erro,
    output logic              ocupado
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {OCIOSO, REQ_IN, REQ_OUT, ESPERA_IN, ESPERA_OUT, FIM} estado_t;

    estado_t           estado, estado_n;
    logic [SW_W-1:0]   chaves_m, chaves_s;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] ext, display_n, dado_in_n;
    logic              escreve_n, concluido_n, erro_n;

    assign ocupado = estado != OCIOSO;

    always_comb begin
        ext         = EXT_SINAL != 0 ? DATA_W'($signed(chaves_s)) : DATA_W'(chaves_s);
        estado_n    = estado;
        cnt_n       = cnt;
        display_n   = display;
        dado_in_n   = dado_in;
        escreve_n   = 1'b0;
        concluido_n = 1'b0;
        erro_n      = erro;
        case (estado)
            OCIOSO: begin
                cnt_n = '0;
                if (exec_in) estado_n = REQ_IN;
                else if (exec_out) begin
                    display_n = dado_reg;
                    estado_n  = REQ_OUT;
                end
            end
            REQ_IN, REQ_OUT: begin
                if (congela) estado_n = (estado == REQ_IN) ? ESPERA_IN : ESPERA_OUT;
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    // the request has been visible for TIMEOUT cycles without a freeze
                    erro_n   = 1'b1;
                    estado_n = FIM;
                end else cnt_n = cnt + 1'b1;
            end
            ESPERA_IN, ESPERA_OUT: begin
                if (!congela) begin
                    concluido_n = 1'b1;
                    estado_n    = FIM;
                    if (estado == ESPERA_IN) begin
                        dado_in_n = ext;
                        escreve_n = 1'b1;
                    end
                end
            end
            FIM: if (!exec_in && !exec_out) estado_n = OCIOSO;
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado          <= OCIOSO;
            chaves_m        <= '0;
            chaves_s        <= '0;
            cnt             <= '0;
            req_congela_in  <= 1'b0;
            req_congela_out <= 1'b0;
            dado_in         <= '0;
            escreve_in      <= 1'b0;
            display         <= '0;
            concluido       <= 1'b0;
            erro            <= 1'b0;
        end else begin
            estado          <= estado_n;
            chaves_m        <= chaves;
            chaves_s        <= chaves_m;
            cnt             <= cnt_n;
            // requests are high exactly while the sequencer sits in a REQ state
            req_congela_in  <= estado_n == REQ_IN;
            req_congela_out <= estado_n == REQ_OUT;
            dado_in         <= dado_in_n;
            escreve_in      <= escreve_n;
            display         <= display_n;
            concluido       <= concluido_n;
            erro            <= erro_n;
        end
    end
endmodule

// File: tb/tb_controle_es.sv
// tb_controle_es: directed and random IN/OUT transactions against a transaction-level model.
module tb_controle_es;
    logic        clk = 0, reset_n = 0, exec_in = 0, exec_out = 0, congela = 0;
    logic [31:0] dado_reg = 0;
    logic [9:0]  chaves = 0;
    logic        req_in0, req_out0, escreve0, concl0, erro0, ocup0;
    logic        req_in1, req_out1, escreve1, concl1, erro1, ocup1;
    logic [31:0] dado_in0, display0, dado_in1, display1;
    int          total = 0, bad = 0;
    logic [31:0] exp_display = 0;
    logic        exp_erro = 0;

    controle_es #(.DATA_W(32), .SW_W(10), .EXT_SINAL(0), .TIMEOUT(16)) u0 (
        .clk(clk), .reset_n(reset_n), .exec_in(exec_in), .exec_out(exec_out),
        .dado_reg(dado_reg), .chaves(chaves), .congela(congela),
        .req_congela_in(req_in0), .req_congela_out(req_out0), .dado_in(dado_in0),
        .escreve_in(escreve0), .display(display0), .concluido(concl0), .erro(erro0),
        .ocupado(ocup0));

    controle_es #(.DATA_W(32), .SW_W(10), .EXT_SINAL(1), .TIMEOUT(16)) u1 (
        .clk(clk), .reset_n(reset_n), .exec_in(exec_in), .exec_out(exec_out),
        .dado_reg(dado_reg), .chaves(chaves), .congela(congela),
        .req_congela_in(req_in1), .req_congela_out(req_out1), .dado_in(dado_in1),
        .escreve_in(escreve1), .display(display1), .concluido(concl1), .erro(erro1),
        .ocupado(ocup1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_in"}, 32'(req_in0), 0);
        chk({tag, " req_out"}, 32'(req_out0), 0);
        chk({tag, " dado_in"}, dado_in0, 0);
        chk({tag, " escreve"}, 32'(escreve0), 0);
        chk({tag, " display"}, display0, 0);
        chk({tag, " concluido"}, 32'(concl0), 0);
        chk({tag, " erro"}, 32'(erro0), 0);
        chk({tag, " ocupado"}, 32'(ocup0), 0);
        chk({tag, " display_ext"}, display1, 0);
    endtask

    // One instruction: held for 60 cycles while the freeze model answers, then released.
    task automatic run_op(input bit do_in, input bit do_out, input logic [9:0] ch,
                          input logic [31:0] dr, input int hold, input bit freeze);
        int n_rin = 0, n_rout = 0, n_both = 0, n_wr = 0, n_wr1 = 0, n_con = 0, left = 0;
        int exp_req;
        logic [31:0] got0 = 0, got1 = 0, ext0, ext1;
        bit raised = 0;
        chaves   = ch;
        dado_reg = dr;
        repeat (3) cyc();
        exec_in  = do_in;
        exec_out = do_out;
        if (!do_in && do_out) exp_display = dr;
        for (int c = 0; c < 60; c++) begin
            cyc();
            n_rin  += int'(req_in0);
            n_rout += int'(req_out0);
            n_both += int'(req_in0 & req_out0);
            n_con  += int'(concl0);
            if (escreve0) begin n_wr++;  got0 = dado_in0; end
            if (escreve1) begin n_wr1++; got1 = dado_in1; end
            chk("display", display0, exp_display);
            if (freeze && !raised && (req_in0 || req_out0)) begin
                congela = 1;
                raised  = 1;
                left    = hold;
            end else if (congela) begin
                if (left == 0) congela = 0;
                else left--;
            end
        end
        exp_req = freeze ? 1 : 16;
        if (!freeze) exp_erro = 1;
        ext0 = 32'(ch);
        ext1 = (ch >= 10'd512) ? 32'(ch) + 32'hFFFF_FC00 : 32'(ch);
        chk("req_in cycles", n_rin, do_in ? exp_req : 0);
        chk("req_out cycles", n_rout, (!do_in && do_out) ? exp_req : 0);
        chk("req overlap", n_both, 0);
        chk("escreve pulses", n_wr, (do_in && freeze) ? 1 : 0);
        chk("escreve pulses ext", n_wr1, (do_in && freeze) ? 1 : 0);
        if (do_in && freeze) begin
            chk("dado_in zext", got0, ext0);
            chk("dado_in sext", got1, ext1);
        end
        chk("concluido pulses", n_con, freeze ? 1 : 0);
        chk("erro", 32'(erro0), 32'(exp_erro));
        chk("ocupado held", 32'(ocup0), 1);
        exec_in  = 0;
        exec_out = 0;
        cyc();
        cyc();
        chk("ocupado released", 32'(ocup0), 0);
        chk("display after", display1, exp_display);
    endtask

    initial begin
        int n;
        repeat (3) cyc();
        chk_all_zero("reset");
        reset_n = 1;
        cyc();

        run_op(1, 0, 10'h2A5, 32'h1234_5678, 20, 1);
        run_op(1, 0, 10'h3FF, 32'h0, 20, 1);
        run_op(0, 1, 10'h155, 32'h0000_BEEF, 12, 1);
        run_op(1, 0, 10'h0F0, 32'hDEAD_0000, 5, 1);
        run_op(1, 1, 10'h200, 32'hCAFE_F00D, 7, 1);
        run_op(0, 1, 10'h001, 32'h0BAD_0BAD, 0, 0);
        run_op(1, 0, 10'h3C3, 32'h0, 3, 1);

        for (int i = 0; i < 16; i++) begin
            n = int'($urandom_range(0, 3));
            run_op(n != 1, n != 0, 10'($urandom), $urandom, int'($urandom_range(0, 30)),
                   $urandom_range(0, 5) != 0);
        end

        // asynchronous reset while waiting for Enter in an IN sequence
        chaves  = 10'h2A5;
        exec_in = 1;
        n = 0;
        while (!req_in0 && n < 10) begin cyc(); n++; end
        chk("req before reset", 32'(req_in0), 1);
        congela = 1;
        repeat (3) cyc();
        chk("ocupado before reset", 32'(ocup0), 1);
        reset_n = 0;
        #1;
        chk_all_zero("mid-espera reset");
        exec_in = 0;
        congela = 0;
        cyc();
        reset_n = 1;
        exp_display = 0;
        exp_erro = 0;
        cyc();
        run_op(0, 1, 10'h0, 32'h0000_1111, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
